unified_mem_arbiter: RTL and testbench

- Shares one unified instruction/data memory port between two requesters in the RISC-V core: instruction fetch (IF) and load/store unit (DM).
- Arbitrates round-robin on simultaneous requests and holds the grant until the memory acknowledges.
- Registers read data back to the winning requester and aborts hung transactions via a timeout.
- Sits between the core's fetch/LSU logic and the memory model instantiated by the top-level testbench.

---
 rtl/unified_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (IF)
// and the load/store unit (DM). The grant is held until mem_ack, or until a
// hung transaction is aborted by the timeout counter. Read data and the
// one-cycle done/err pulses are registered back to the requester that won.
module unified_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_done,

    input  logic            dm_req,
    input  logic [AW-1:0]   dm_addr,
    input  logic            dm_we,
    input  logic [DW-1:0]   dm_wdata,
    input  logic [DW/8-1:0] dm_wstrb,
    output logic [DW-1:0]   dm_rdata,
    output logic            dm_done,

    output logic            err,

    output logic            mem_req,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_we,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wstrb,
    input  logic            mem_ack,
    input  logic [DW-1:0]   mem_rdata,

    output logic            busy,
    output logic            grant_dm
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    // The counter is always at least one bit wide, so TIMEOUT=0 still elaborates.
    localparam int             CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  TO_LIMIT = CW'(TIMEOUT);

    state_t        state;
    state_t        state_next;
    logic          last_dm;      // 1 = DM was served last, so IF wins the next tie
    logic [CW-1:0] wait_cnt;

    logic          if_elig;
    logic          dm_elig;
    logic          pick_dm;
    logic          timeout_hit;
    logic          start;
    logic          finish;

    // A requester whose done pulse is high this cycle still has req asserted;
    // it must not be granted a second time off that stale request.
    assign if_elig = if_req && !if_done;
    assign dm_elig = dm_req && !dm_done;
    assign pick_dm = dm_elig && (!if_elig || !last_dm);

    // Abort on the edge where the no-ack count would reach TIMEOUT, so mem_req
    // stays high for exactly TIMEOUT cycles.
    assign timeout_hit = (TIMEOUT != 0) && !mem_ack && ((wait_cnt + CW'(1)) == TO_LIMIT);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic: grant from IDLE, return to IDLE on ack or abort.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_next
        // unassigned, which would infer a latch.
        state_next = state;
        unique case (state)
            IDLE: begin
                if (if_elig || dm_elig) state_next = pick_dm ? BUSY_DM : BUSY_IF;
            end
            BUSY_IF, BUSY_DM: begin
                if (mem_ack || timeout_hit) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode: busy flag and the grant/finish strobes for the datapath.
    always_comb begin
        busy   = (state != IDLE);
        start  = (state == IDLE) && (if_elig || dm_elig);
        finish = (state != IDLE) && (mem_ack || timeout_hit);
    end

    // Registered datapath: memory command, return data, done/err pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            if_rdata  <= '0;
            if_done   <= 1'b0;
            dm_rdata  <= '0;
            dm_done   <= 1'b0;
            err       <= 1'b0;
            grant_dm  <= 1'b0;
            last_dm   <= 1'b1;
            wait_cnt  <= '0;
        end else begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
            err     <= 1'b0;
            if (start) begin
                mem_req   <= 1'b1;
                mem_addr  <= pick_dm ? dm_addr : if_addr;
                mem_we    <= pick_dm && dm_we;
                mem_wdata <= pick_dm ? dm_wdata : '0;
                mem_wstrb <= pick_dm ? dm_wstrb : '0;
                grant_dm  <= pick_dm;
                last_dm   <= pick_dm;
                wait_cnt  <= '0;
            end else if (finish) begin
                mem_req <= 1'b0;
                err     <= !mem_ack;
                if (state == BUSY_DM) begin
                    dm_done  <= 1'b1;
                    dm_rdata <= mem_ack ? mem_rdata : '0;
                end else begin
                    if_done  <= 1'b1;
                    if_rdata <= mem_ack ? mem_rdata : '0;
                end
            end else if (state != IDLE) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter. Inputs are driven 1 ns after each
// rising edge and outputs are checked at the same point, i.e. every check
// sees the registered values for the cycle that just began.
module tb_unified_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic [DW-1:0]   if_rdata;
    logic            if_done;
    logic            dm_req;
    logic [AW-1:0]   dm_addr;
    logic            dm_we;
    logic [DW-1:0]   dm_wdata;
    logic [DW/8-1:0] dm_wstrb;
    logic [DW-1:0]   dm_rdata;
    logic            dm_done;
    logic            err;
    logic            mem_req;
    logic [AW-1:0]   mem_addr;
    logic            mem_we;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_wstrb;
    logic            mem_ack;
    logic [DW-1:0]   mem_rdata;
    logic            busy;
    logic            grant_dm;

    int n_checks = 0;
    int n_fail   = 0;

    unified_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_done  (if_done),
        .dm_req   (dm_req),
        .dm_addr  (dm_addr),
        .dm_we    (dm_we),
        .dm_wdata (dm_wdata),
        .dm_wstrb (dm_wstrb),
        .dm_rdata (dm_rdata),
        .dm_done  (dm_done),
        .err      (err),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .grant_dm (grant_dm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        logic [1:0] exp_grant [4];
        exp_grant = '{2'd0, 2'd1, 2'd0, 2'd1};

        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_addr = '0; dm_we = 1'b0; dm_wdata = '0; dm_wstrb = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        step(); step();
        rst = 1'b0;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_err", {29'd0, if_done, dm_done, err}, 32'd0);
        check("rst_grant_dm", 32'(grant_dm), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);

        // IF read, ack one cycle after mem_req rises
        if_req = 1'b1; if_addr = 32'h4;
        step();
        check("if_mem_req", 32'(mem_req), 32'd1);
        check("if_mem_addr", mem_addr, 32'h4);
        check("if_mem_we", 32'(mem_we), 32'd0);
        check("if_grant_dm", 32'(grant_dm), 32'd0);
        check("if_early_done", 32'(if_done), 32'd0);
        step();
        check("if_wait_mem_req", 32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h293;
        step();
        mem_ack = 1'b0; mem_rdata = '0;
        check("if_done", 32'(if_done), 32'd1);
        check("if_rdata", if_rdata, 32'h293);
        check("if_dm_done", 32'(dm_done), 32'd0);
        check("if_err", 32'(err), 32'd0);
        if_req = 1'b0;
        step();
        check("if_done_pulse", 32'(if_done), 32'd0);
        check("if_idle_busy", 32'(busy), 32'd0);

        // DM write, zero-wait memory
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF; dm_wstrb = 4'hF;
        step();
        check("dmw_mem_req", 32'(mem_req), 32'd1);
        check("dmw_mem_addr", mem_addr, 32'h100);
        check("dmw_mem_we", 32'(mem_we), 32'd1);
        check("dmw_mem_wdata", mem_wdata, 32'hDEADBEEF);
        check("dmw_mem_wstrb", 32'(mem_wstrb), 32'hF);
        check("dmw_grant_dm", 32'(grant_dm), 32'd1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("dmw_done", 32'(dm_done), 32'd1);
        check("dmw_err", 32'(err), 32'd0);
        check("dmw_if_done", 32'(if_done), 32'd0);
        dm_req = 1'b0; dm_we = 1'b0; dm_wdata = '0; dm_wstrb = '0;
        step();

        // Both requesting: round-robin IF, DM, IF, DM
        if_req = 1'b1; if_addr = 32'h4; dm_req = 1'b1; dm_addr = 32'h100;
        step();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr%0d_mem_req", i), 32'(mem_req), 32'd1);
            check($sformatf("rr%0d_grant_dm", i), 32'(grant_dm), 32'(exp_grant[i]));
            check($sformatf("rr%0d_mem_addr", i), mem_addr, exp_grant[i][0] ? 32'h100 : 32'h4);
            check($sformatf("rr%0d_mem_we", i), 32'(mem_we), 32'd0);
            mem_ack = 1'b1; mem_rdata = 32'h1000 + 32'(i);
            step();
            mem_ack = 1'b0; mem_rdata = '0;
            check($sformatf("rr%0d_dones", i), {30'd0, if_done, dm_done},
                  exp_grant[i][0] ? 32'd1 : 32'd2);
            check($sformatf("rr%0d_rdata", i), exp_grant[i][0] ? dm_rdata : if_rdata,
                  32'h1000 + 32'(i));
            if (i == 3) begin
                if_req = 1'b0; dm_req = 1'b0;
            end
            step();
        end
        check("rr_end_busy", 32'(busy), 32'd0);

        // DM read that never gets an ack: abort after 16 cycles
        dm_req = 1'b1; dm_addr = 32'h200; mem_rdata = 32'h0BAD_0BAD;
        step();
        cnt = 0;
        while (mem_req && cnt < 40) begin
            cnt++;
            check("to_no_done", {30'd0, if_done, dm_done}, 32'd0);
            step();
        end
        check("to_req_cycles", 32'(cnt), 32'd16);
        check("to_dm_done", 32'(dm_done), 32'd1);
        check("to_err", 32'(err), 32'd1);
        check("to_dm_rdata", dm_rdata, 32'd0);
        check("to_busy", 32'(busy), 32'd0);
        dm_req = 1'b0;
        step();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; mem_rdata = '0;
        check("late_ack_done", {29'd0, if_done, dm_done, err}, 32'd0);
        check("late_ack_busy", 32'(busy), 32'd0);
        step();
        check("late_ack_done2", {29'd0, if_done, dm_done, err}, 32'd0);
        check("late_ack_req", 32'(mem_req), 32'd0);

        // Reset during BUSY_IF, ack would have arrived in cycle 3
        if_req = 1'b1; if_addr = 32'h8;
        step();
        check("rstb_mem_req", 32'(mem_req), 32'd1);
        step();
        rst = 1'b1;
        step();
        check("rstb_drop_req", 32'(mem_req), 32'd0);
        check("rstb_busy", 32'(busy), 32'd0);
        check("rstb_no_done", {29'd0, if_done, dm_done, err}, 32'd0);
        rst = 1'b0; if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555;
        step();
        mem_ack = 1'b0; mem_rdata = '0;
        check("rstb_ack_ignored", {29'd0, if_done, dm_done, err}, 32'd0);

        // Fresh IF after reset; req held one cycle past done
        if_req = 1'b1; if_addr = 32'hC;
        step();
        check("fresh_mem_req", 32'(mem_req), 32'd1);
        check("fresh_mem_addr", mem_addr, 32'hC);
        mem_ack = 1'b1; mem_rdata = 32'h1234;
        step();
        mem_ack = 1'b0; mem_rdata = '0;
        check("fresh_done", 32'(if_done), 32'd1);
        check("fresh_rdata", if_rdata, 32'h1234);
        step();
        check("hold_no_regrant", 32'(mem_req), 32'd0);
        check("hold_idle", 32'(busy), 32'd0);
        check("hold_done_pulse", 32'(if_done), 32'd0);
        step();
        check("hold_regrant", 32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h77;
        step();
        mem_ack = 1'b0; mem_rdata = '0; if_req = 1'b0;
        check("regrant_done", 32'(if_done), 32'd1);
        check("regrant_rdata", if_rdata, 32'h77);
        step();
        check("final_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
